// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, limits and helpers for the parametrised SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 32;
  localparam int NUM_CS_MIN = 1;
  localparam int NUM_CS_MAX = 16;

  // Leading edges sample when cpha=0, trailing edges sample when cpha=1.
  function automatic logic is_sample_edge(input spi_mode_t mode, input logic leading);
    return leading ^ mode.cpha;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - loadable half-period counter emitting one tick every div_i+1 cycles
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  // Restart from zero on load, wrap to zero on every tick, never count past div_i.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - SPI master with runtime mode, bit order and divider per transfer
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              spi_miso,
  output logic              spi_mosi,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EC_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  spi_state_t          state_q;
  spi_mode_t           mode_q;
  logic [DIV_W-1:0]    div_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic [DATA_W-1:0]   rx_sh_q;
  logic [EC_W-1:0]     edge_cnt_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   rx_data_q;

  logic                accept;
  logic                tick;
  logic                tick_en;
  logic [NUM_CS-1:0]   cs_dec_d;
  logic                first_bit_d;
  logic [DATA_W-1:0]   first_shift_d;
  logic                tx_bit_d;
  logic [DATA_W-1:0]   tx_shift_d;
  logic [DATA_W-1:0]   rx_next_d;
  logic                leading;
  logic                sample_now;
  logic                last_edge;

  assign accept  = (state_q == IDLE) && start;
  assign tick_en = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

  spi_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .en_i   (tick_en),
    .div_i  (div_q),
    .tick_o (tick)
  );

  assign leading    = ~edge_cnt_q[0];
  assign sample_now = is_sample_edge(mode_q, leading);
  assign last_edge  = (edge_cnt_q == LAST_EDGE);

  // Chip-select decode; an out-of-range index leaves every line deasserted.
  always_comb begin
    cs_dec_d = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) begin
        cs_dec_d[i] = 1'b0;
      end
    end
  end

  // Next TX bit and shifted words for the accepted word and the in-flight shift register.
  always_comb begin
    first_bit_d   = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    first_shift_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
    tx_bit_d      = mode_q.lsb_first ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    tx_shift_d    = mode_q.lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    rx_next_d     = mode_q.lsb_first ? {spi_miso, rx_sh_q[DATA_W-1:1]}
                                     : {rx_sh_q[DATA_W-2:0], spi_miso};
  end

  // Transfer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      div_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SETUP;
            mode_q     <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
            div_q      <= clk_div;
            cs_n_q     <= cs_dec_d;
            busy_q     <= 1'b1;
            sclk_q     <= cpol;
            edge_cnt_q <= '0;
            rx_sh_q    <= '0;
            if (!cpha) begin
              mosi_q  <= first_bit_d;
              tx_sh_q <= first_shift_d;
            end else begin
              tx_sh_q <= tx_data;
            end
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= XFER;
          end
        end
        XFER: begin
          if (tick) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + EC_W'(1);
            if (sample_now) begin
              rx_sh_q <= rx_next_d;
            end else if (!last_edge) begin
              mosi_q  <= tx_bit_d;
              tx_sh_q <= tx_shift_d;
            end
            if (last_edge) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          sclk_q <= mode_q.cpol;
          if (tick) begin
            state_q   <= DONE;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sh_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_mosi = mosi_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;

endmodule
